neuron_backprop: RTL and testbench
==================================

NEURON_BACKPROP -- requirements
Module: neuron_backprop

Interface
REQ-001 Parameter N, default 8: number of weights/inputs, N >= 2.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 load_en  input  1  write load_w into weight[load_idx] (IDLE only).
REQ-005 load_idx  input  clog2(N)  weight index for load.
REQ-006 load_w  input  8  signed Q1.6 weight value.
REQ-007 start  input  1  begin update pass (IDLE only).
REQ-008 lr  input  8  signed Q1.6 learning rate, sampled on accepted start.
REQ-009 delta  input  8  signed Q1.6 error term, sampled on accepted start.
REQ-010 x_valid  input  1  x_data valid.
REQ-011 x_data  input  8  signed Q1.6 forward input x[i].
REQ-012 x_ready  output  1  block accepts x_data.
REQ-013 upd_valid  output  1  one-cycle strobe: upd_idx/upd_w/eb_out valid.
REQ-014 upd_idx  output  clog2(N)  index of updated weight.
REQ-015 upd_w  output  8  new weight[i].
REQ-016 eb_out  output  8  back-propagated error sat(weight_old[i]*delta).
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 done  output  1  one-cycle pulse at pass end.
REQ-019 ovr  output  1  sticky saturation flag for the current pass.

Function
REQ-020 Multiply rule: mul(a,b) = 16-bit signed product, arithmetic shift right by 6 (floor), saturated to [-128,127].
REQ-021 Subtract rule: sub(a,b) = 9-bit signed a-b, saturated to [-128,127].
REQ-022 States: IDLE, SCALE, STREAM, DONE; reset enters IDLE.
REQ-023 IDLE: start=1 -> latch lr and delta, clear ovr, clear index to 0, go to SCALE; start has priority over a same-cycle load_en, which is dropped.
REQ-024 IDLE with load_en=1 and start=0: weight[load_idx] <= load_w next edge; load_en outside IDLE is ignored.
REQ-025 SCALE (1 cycle): g <= mul(lr, delta); go to STREAM.
REQ-026 STREAM: x_ready=1; on x_valid&x_ready for index i: weight[i] <= sub(weight[i], mul(g, x_data)).
REQ-027 On the same handshake, register upd_valid=1, upd_idx=i, upd_w=new weight, eb_out=mul(weight_old[i], delta); all are visible the cycle after the handshake (latency 1).
REQ-028 Output has no backpressure; upd_valid=0 in every cycle without a handshake in the prior cycle.
REQ-029 Index increments per handshake; the handshake at index N-1 moves the FSM to DONE and deasserts x_ready.
REQ-030 DONE (1 cycle): done=1 (coincides with final upd_valid); then IDLE.
REQ-031 ovr sets when any mul or sub in the pass saturates, including g; it holds until the next accepted start or reset.
REQ-032 start during SCALE/STREAM/DONE is ignored; x_valid outside STREAM is ignored.
REQ-033 lr=0 or delta=0: weights unchanged, upd_w equals old weight.

Reset
REQ-034 rst=0 asynchronously: FSM to IDLE, all weights, g, index, latched lr/delta cleared to 0; x_ready, upd_valid, upd_idx, upd_w, eb_out, busy, done, ovr = 0.
REQ-035 Reset mid-pass abandons the pass; no further upd_valid or done; already-updated weights are also cleared.

Configuration
REQ-036 Macro NEURON_BP_ERR_EN defined: eb_out computed per REQ-027, and its saturation contributes to ovr.
REQ-037 Macro absent: eb_out held 0, its multiplier omitted, ovr covers only g/update saturation; ports unchanged.

Verification
REQ-038 Load w[0]=64; start with lr=32, delta=32; x=64 -> g=16, upd_w=48, eb_out=32, ovr=0, done with the 8th upd_valid.
REQ-039 w[3]=-128, lr=127, delta=127, x[3]=127 -> g=127 (saturated), upd_w=-128, eb_out=-128, ovr=1 held until next start.
REQ-040 x_valid toggled 0/1 in STREAM -> exactly N upd_valid strobes, upd_idx 0..N-1 in order, each one cycle after its handshake.
REQ-041 start and load_en both high in IDLE -> pass starts and the weight is not written; load_en during busy -> weight unchanged.
REQ-042 rst low at index 4 -> all outputs 0 immediately; after release, read-back pass with lr=0 shows all upd_w=0.
REQ-043 Negative floor: g=-1 (lr=-64, delta=1), x=1, w=0 -> mul=-1, upd_w=1.

Source files
------------

// File: rtl/neuron_backprop_if.sv
// neuron_backprop_if: weight-load, pass-start, x-stream and update-stream signals of neuron_backprop.
interface neuron_backprop_if #(
  parameter int N = 8
);
  localparam int IW = $clog2(N);

  logic                 load_en;
  logic [IW-1:0]        load_idx;
  logic signed [7:0]    load_w;
  logic                 start;
  logic signed [7:0]    lr;
  logic signed [7:0]    delta;
  logic                 x_valid;
  logic signed [7:0]    x_data;
  logic                 x_ready;
  logic                 upd_valid;
  logic [IW-1:0]        upd_idx;
  logic signed [7:0]    upd_w;
  logic signed [7:0]    eb_out;
  logic                 busy;
  logic                 done;
  logic                 ovr;

  modport master (
    output load_en, load_idx, load_w, start, lr, delta, x_valid, x_data,
    input  x_ready, upd_valid, upd_idx, upd_w, eb_out, busy, done, ovr
  );

  modport slave (
    input  load_en, load_idx, load_w, start, lr, delta, x_valid, x_data,
    output x_ready, upd_valid, upd_idx, upd_w, eb_out, busy, done, ovr
  );
endinterface

// File: rtl/neuron_backprop.sv
// neuron_backprop: streaming Q1.6 weight update w[i] -= (lr*delta)*x[i] for one neuron.
// Define NEURON_BP_ERR_EN to also produce eb_out = weight_old[i]*delta (otherwise eb_out stays 0).
module neuron_backprop #(
  parameter int N = 8
) (
  input logic              clk,
  input logic              rst,
  neuron_backprop_if.slave bus
);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SCALE, STREAM, DONE} state_t;
  typedef struct packed {
    logic signed [7:0] v;
    logic              sat;
  } sat_t;

  // Q1.6 product: floor shift by 6, then clamp to the 8-bit range.
  function automatic sat_t mul_q6(input logic signed [7:0] a, input logic signed [7:0] b);
    logic signed [15:0] p;
    logic signed [15:0] s;
    sat_t               r;
    p = 16'(a) * 16'(b);
    s = p >>> 6;
    if (s > 16'sd127) begin
      r.v   = 8'sd127;
      r.sat = 1'b1;
    end else if (s < -16'sd128) begin
      r.v   = -8'sd128;
      r.sat = 1'b1;
    end else begin
      r.v   = s[7:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

  function automatic sat_t sub_q6(input logic signed [7:0] a, input logic signed [7:0] b);
    logic signed [8:0] d;
    sat_t              r;
    d = 9'(a) - 9'(b);
    if (d > 9'sd127) begin
      r.v   = 8'sd127;
      r.sat = 1'b1;
    end else if (d < -9'sd128) begin
      r.v   = -8'sd128;
      r.sat = 1'b1;
    end else begin
      r.v   = d[7:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

  state_t            state;
  logic signed [7:0] weight [N];
  logic signed [7:0] g;
  logic signed [7:0] lr_q;
  logic signed [7:0] delta_q;
  logic [IW-1:0]     idx;

  sat_t g_next;
  sat_t dw;
  sat_t w_new;
  sat_t eb;
  logic hs;

  assign g_next = mul_q6(lr_q, delta_q);
  assign dw     = mul_q6(g, bus.x_data);
  assign w_new  = sub_q6(weight[idx], dw.v);
  assign hs     = (state == STREAM) && bus.x_valid && bus.x_ready;

`ifdef NEURON_BP_ERR_EN
  assign eb = mul_q6(weight[idx], delta_q);
`else
  assign eb = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      g       <= '0;
      lr_q    <= '0;
      delta_q <= '0;
      idx     <= '0;
      // NOTE: weights live in flops, so clearing them on reset is both legal and expected.
      for (int i = 0; i < N; i++) weight[i] <= '0;
      bus.x_ready   <= 1'b0;
      bus.upd_valid <= 1'b0;
      bus.upd_idx   <= '0;
      bus.upd_w     <= '0;
      bus.eb_out    <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.ovr       <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle so a set lasts exactly one cycle.
      bus.upd_valid <= 1'b0;
      bus.done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            lr_q     <= bus.lr;
            delta_q  <= bus.delta;
            bus.ovr  <= 1'b0;
            idx      <= '0;
            bus.busy <= 1'b1;
            state    <= SCALE;
          end else if (bus.load_en) begin
            weight[bus.load_idx] <= bus.load_w;
          end
        end
        SCALE: begin
          g <= g_next.v;
          if (g_next.sat) bus.ovr <= 1'b1;
          bus.x_ready <= 1'b1;
          state       <= STREAM;
        end
        STREAM: begin
          if (hs) begin
            weight[idx]   <= w_new.v;
            bus.upd_valid <= 1'b1;
            bus.upd_idx   <= idx;
            bus.upd_w     <= w_new.v;
            bus.eb_out    <= eb.v;
            if (dw.sat || w_new.sat || eb.sat) bus.ovr <= 1'b1;
            // done is registered here so it lands in the same cycle as the final update.
            if (idx == IW'(N - 1)) begin
              bus.x_ready <= 1'b0;
              bus.done    <= 1'b1;
              state       <= DONE;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_backprop.sv
// tb_neuron_backprop: table-driven passes plus hand sequences, checked against a scoreboard model.
module tb_neuron_backprop;
  localparam int N = 8;

  logic clk;
  logic rst;

  neuron_backprop_if #(.N(N)) bus ();

  neuron_backprop #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic written with integer division rather than shifts.
  function automatic int qmul(input int a, input int b, output bit s);
    int p;
    int q;
    p = a * b;
    q = (p >= 0) ? p / 64 : -((-p + 63) / 64);
    s = 1'b0;
    if (q > 127) begin q = 127; s = 1'b1; end
    else if (q < -128) begin q = -128; s = 1'b1; end
    return q;
  endfunction

  function automatic int qsub(input int a, input int b, output bit s);
    int d;
    d = a - b;
    s = 1'b0;
    if (d > 127) begin d = 127; s = 1'b1; end
    else if (d < -128) begin d = -128; s = 1'b1; end
    return d;
  endfunction

  typedef struct {
    int due;
    int idx;
    int w;
    int eb;
  } exp_t;

  typedef int xvec_t [N];

  exp_t sb[$];
  int   mw [N];
  int   cap_w [N];
  int   cap_eb [N];
  int   m_g, m_delta, m_idx, strobes, ncyc;
  bit   m_ovr;

  // Monitor then model, both on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    bit   s1, s2, s3;
    int   old, p, nw, ebv;
    ncyc++;
    if (rst === 1'b1) begin
      if (bus.upd_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_upd", 1, 0);
        end else begin
          e = sb.pop_front();
          check("upd_latency", ncyc, e.due);
          check("upd_idx", bus.upd_idx, e.idx);
          check("upd_w", bus.upd_w, e.w);
          check("eb_out", bus.eb_out, e.eb);
          check("done_with_last", bus.done, (e.idx == N - 1) ? 1 : 0);
          cap_w[e.idx]  = int'(bus.upd_w);
          cap_eb[e.idx] = int'(bus.eb_out);
          strobes++;
        end
      end else begin
        if (bus.done) check("stray_done", 1, 0);
        if (sb.size() > 0 && sb[0].due <= ncyc) begin
          check("upd_missing", 0, 1);
          void'(sb.pop_front());
        end
      end

      if (bus.x_valid && bus.x_ready) begin
        if (m_idx >= N) begin
          check("extra_handshake", m_idx, N - 1);
        end else begin
          old = mw[m_idx];
          p   = qmul(m_g, int'(bus.x_data), s1);
          nw  = qsub(old, p, s2);
          ebv = qmul(old, m_delta, s3);
`ifdef NEURON_BP_ERR_EN
          if (s1 || s2 || s3) m_ovr = 1'b1;
`else
          ebv = 0;
          if (s1 || s2) m_ovr = 1'b1;
`endif
          mw[m_idx] = nw;
          sb.push_back('{ncyc + 1, m_idx, nw, ebv});
          m_idx++;
        end
      end
    end
  end

  task automatic load(input int idx, input int w);
    @(posedge clk); #1;
    bus.load_en  = 1'b1;
    bus.load_idx = 3'(idx);
    bus.load_w   = 8'(w);
    @(posedge clk); #1;
    bus.load_en = 1'b0;
    mw[idx] = w;
  endtask

  task automatic run_pass(input int lr, input int delta, input xvec_t xs,
                          input bit gap, input bit conflict);
    bit hs;
    bit s;
    int guard;
    for (int i = 0; i < N; i++) begin cap_w[i] = 999; cap_eb[i] = 999; end
    @(negedge clk);
    check("ovr_hold_idle", bus.ovr, m_ovr);
    check("busy_idle", bus.busy, 0);
    check("x_ready_idle", bus.x_ready, 0);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.lr    = 8'(lr);
    bus.delta = 8'(delta);
    if (conflict) begin
      bus.load_en  = 1'b1;
      bus.load_idx = 3'd6;
      bus.load_w   = -8'sd99;
    end
    m_g     = qmul(lr, delta, s);
    m_ovr   = s;
    m_delta = delta;
    m_idx   = 0;
    strobes = 0;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.lr      = 8'sd99;
    bus.delta   = -8'sd77;
    bus.x_valid = 1'b1;
    bus.x_data  = 8'(xs[0]);
    if (conflict) bus.load_w = 8'sd55;
    @(negedge clk);
    check("ovr_clear_on_start", bus.ovr, 0);
    check("busy_scale", bus.busy, 1);
    check("x_ready_scale", bus.x_ready, 0);
    for (int i = 0; i < N; i++) begin
      if (gap && (i % 2 == 1)) begin
        bus.x_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.x_valid = 1'b1;
      bus.x_data  = 8'(xs[i]);
      if (conflict && i == 2) begin
        bus.start = 1'b1;
        bus.lr    = 8'sd127;
        bus.delta = 8'sd127;
      end
      guard = 0;
      do begin
        @(negedge clk);
        hs = bus.x_ready;
        @(posedge clk); #1;
        guard++;
      end while (!hs && guard < 20);
      bus.start = 1'b0;
      if (!hs) begin
        check("x_ready_timeout", 0, 1);
        break;
      end
    end
    bus.x_valid = 1'b0;
    bus.load_en = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!bus.done && guard < 10);
    check("done_seen", bus.done, 1);
    @(negedge clk);
    check("busy_after_done", bus.busy, 0);
    check("done_one_cycle", bus.done, 0);
    check("ovr_pass_end", bus.ovr, m_ovr);
    check("strobe_count", strobes, N);
  endtask

  typedef struct {
    int k;
    int wk;
    int lr;
    int delta;
    int xk;
    int xo;
    bit gap;
    int exp_w;
    int exp_eb;
    bit exp_ovr;
  } vec_t;

  vec_t  vecs [7];
  xvec_t xs;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [22:0] outs;
    int          hs_cnt;
    int          guard;
    vecs[0] = '{0,   64,   32,   32,  64, 64, 1'b0,   48,   32, 1'b0};
    vecs[1] = '{3, -128,  127,  127, 127,  0, 1'b0, -128, -128, 1'b1};
    vecs[2] = '{5,    0,  -64,    1,   1,  0, 1'b1,    1,    0, 1'b0};
    vecs[3] = '{2,  100,    0,   50,-100,  0, 1'b1,  100,   78, 1'b0};
    vecs[4] = '{7,  -77,   90,    0, 120, 10, 1'b0,  -77,    0, 1'b0};
    vecs[5] = '{1,  127, -128,  127,  64,  0, 1'b0,  127,  127, 1'b1};
    vecs[6] = '{4,  -50,   40,  -30, -90,  0, 1'b1,  -76,   23, 1'b0};

    rst = 1'b0;
    bus.load_en = 1'b0; bus.load_idx = '0; bus.load_w = '0;
    bus.start = 1'b0; bus.lr = '0; bus.delta = '0;
    bus.x_valid = 1'b0; bus.x_data = '0;
    m_ovr = 1'b0; m_idx = 0; m_g = 0; m_delta = 0; ncyc = 0; strobes = 0;
    for (int i = 0; i < N; i++) mw[i] = 0;
    repeat (3) @(negedge clk);
    outs = {bus.x_ready, bus.upd_valid, bus.upd_idx, bus.upd_w, bus.eb_out,
            bus.busy, bus.done, bus.ovr};
    check("reset_outputs", 32'(outs), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int v = 0; v < 7; v++) begin
      load(vecs[v].k, vecs[v].wk);
      for (int i = 0; i < N; i++) xs[i] = vecs[v].xo;
      xs[vecs[v].k] = vecs[v].xk;
      run_pass(vecs[v].lr, vecs[v].delta, xs, vecs[v].gap, 1'b0);
      check("vec_upd_w", cap_w[vecs[v].k], vecs[v].exp_w);
`ifdef NEURON_BP_ERR_EN
      check("vec_eb_out", cap_eb[vecs[v].k], vecs[v].exp_eb);
`else
      check("vec_eb_out", cap_eb[vecs[v].k], 0);
`endif
      check("vec_ovr", bus.ovr, vecs[v].exp_ovr);
    end

    // start wins over a same-cycle load; loads while busy are dropped
    load(6, 33);
    for (int i = 0; i < N; i++) xs[i] = 20;
    run_pass(0, 1, xs, 1'b0, 1'b1);
    check("conflict_w6", cap_w[6], 33);

    // reset in the middle of a pass at index 4
    @(posedge clk); #1;
    bus.start = 1'b1; bus.lr = 8'sd64; bus.delta = 8'sd64;
    m_g = 64; m_delta = 64; m_idx = 0; m_ovr = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.x_valid = 1'b1; bus.x_data = 8'sd10;
    hs_cnt = 0;
    guard  = 0;
    while (hs_cnt < 4 && guard < 30) begin
      @(negedge clk);
      if (bus.x_ready) hs_cnt++;
      @(posedge clk); #1;
      guard++;
    end
    check("midpass_handshakes", hs_cnt, 4);
    check("midpass_busy", bus.busy, 1);
    bus.x_valid = 1'b0;
    sb.delete();
    rst = 1'b0;
    #1;
    outs = {bus.x_ready, bus.upd_valid, bus.upd_idx, bus.upd_w, bus.eb_out,
            bus.busy, bus.done, bus.ovr};
    check("midpass_reset_outputs", 32'(outs), 0);
    for (int i = 0; i < N; i++) mw[i] = 0;
    m_ovr = 1'b0;
    m_idx = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_upd_after_reset", bus.upd_valid, 0);
      check("no_done_after_reset", bus.done, 0);
    end

    for (int i = 0; i < N; i++) xs[i] = 5 * i - 17;
    run_pass(0, 0, xs, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) check("readback_zero", cap_w[i], 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
